// File: rtl/mult_pkg.sv
// Shared types and constants for the repeated-addition multiplier control path.
package mult_pkg;

  localparam int MULTIPLIER_WIDTH = 3;
  localparam int MAX_ITER         = 2**MULTIPLIER_WIDTH - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ADD,
    ST_INC,
    ST_STORE,
    ST_DONE
  } mult_state_t;

  localparam logic [2:0] ALU_INC  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_ZERO = 3'b010;

  localparam logic [1:0] SEL_R2 = 2'd0;
  localparam logic [1:0] SEL_A  = 2'd1;
  localparam logic [1:0] SEL_R1 = 2'd0;

endpackage

// File: rtl/mult_controller.sv
// Control FSM for the 3x3 repeated-addition multiplier; drives datapath selects,
// ALU opcode and load enables, and offers a START/BUSY/DONE handshake.
//
//   state    | meaning
//   ST_IDLE  | waiting for START; A/B load on START
//   ST_INIT  | clear R1 and R2
//   ST_ADD   | R1 <= R1 + A, test EQUAL / watchdog
//   ST_INC   | R2 <= R2 + 1
//   ST_STORE | Y <= R1
//   ST_DONE  | one-cycle DONE pulse
module mult_controller
  import mult_pkg::*;
(
  input  logic                        SYS_CLOCK,
  input  logic                        SYS_RESET,
  input  logic                        START,
  input  logic [MULTIPLIER_WIDTH-1:0] B,
  input  logic                        EQUAL,
  output logic [1:0]                  MUX_IN1_CONT,
  output logic [1:0]                  MUX_IN2_CONT,
  output logic [2:0]                  ALU_CONT,
  output logic                        LOAD_A_REG,
  output logic                        LOAD_B_REG,
  output logic                        LOAD_R1_REG,
  output logic                        LOAD_R2_REG,
  output logic                        LOAD_Y_REG,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        ERROR
);

  localparam logic [MULTIPLIER_WIDTH-1:0] ITER_LAST = MULTIPLIER_WIDTH'(MAX_ITER - 1);
  localparam logic [MULTIPLIER_WIDTH-1:0] ITER_ONE  = MULTIPLIER_WIDTH'(1);

  mult_state_t                 state, state_nxt;
  logic [MULTIPLIER_WIDTH-1:0] iter_cnt;
  logic                        bzero;
  logic                        error_q;
  logic                        start_acc;
  logic                        watchdog_hit;

  assign start_acc    = (state == ST_IDLE) && START;
  assign watchdog_hit = (state == ST_ADD) && !EQUAL && (iter_cnt == ITER_LAST);
  assign ERROR        = error_q;

  always_ff @(posedge SYS_CLOCK) begin
    if (SYS_RESET) begin
      state    <= ST_IDLE;
      iter_cnt <= '0;
      bzero    <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        bzero    <= (B == '0);
        iter_cnt <= '0;
        error_q  <= 1'b0;
      end
      // The counter stops at MAX_ITER because the last ADD always leaves for STORE.
      if (state == ST_ADD) begin
        iter_cnt <= iter_cnt + ITER_ONE;
      end
      if (watchdog_hit) begin
        error_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    MUX_IN1_CONT = SEL_R2;
    MUX_IN2_CONT = SEL_R1;
    ALU_CONT     = ALU_ZERO;
    LOAD_A_REG   = 1'b0;
    LOAD_B_REG   = 1'b0;
    LOAD_R1_REG  = 1'b0;
    LOAD_R2_REG  = 1'b0;
    LOAD_Y_REG   = 1'b0;
    BUSY         = 1'b1;
    DONE         = 1'b0;
    case (state)
      ST_IDLE: begin
        BUSY = 1'b0;
        // Held off during reset so a START under reset cannot disturb the datapath.
        LOAD_A_REG = START && !SYS_RESET;
        LOAD_B_REG = START && !SYS_RESET;
        if (START) state_nxt = ST_INIT;
      end
      ST_INIT: begin
        ALU_CONT    = ALU_ZERO;
        LOAD_R1_REG = 1'b1;
        LOAD_R2_REG = 1'b1;
        state_nxt   = bzero ? ST_STORE : ST_ADD;
      end
      ST_ADD: begin
        MUX_IN1_CONT = SEL_A;
        MUX_IN2_CONT = SEL_R1;
        ALU_CONT     = ALU_ADD;
        LOAD_R1_REG  = 1'b1;
        if (EQUAL || watchdog_hit) state_nxt = ST_STORE;
        else                       state_nxt = ST_INC;
      end
      ST_INC: begin
        MUX_IN1_CONT = SEL_R2;
        ALU_CONT     = ALU_INC;
        LOAD_R2_REG  = 1'b1;
        state_nxt    = ST_ADD;
      end
      ST_STORE: begin
        LOAD_Y_REG = 1'b1;
        state_nxt  = ST_DONE;
      end
      ST_DONE: begin
        DONE      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_controller.sv
// Directed bench for mult_controller with a small behavioural datapath attached.
module tb_mult_controller;
  import mult_pkg::*;

  logic       SYS_CLOCK = 1'b0;
  logic       SYS_RESET;
  logic       START;
  logic [2:0] B;
  logic       EQUAL;
  logic [1:0] MUX_IN1_CONT, MUX_IN2_CONT;
  logic [2:0] ALU_CONT;
  logic       LOAD_A_REG, LOAD_B_REG, LOAD_R1_REG, LOAD_R2_REG, LOAD_Y_REG;
  logic       BUSY, DONE, ERROR;

  int checks = 0;
  int passed = 0;

  logic [2:0] a_in = 3'd0;
  logic [2:0] a_reg = 3'd0, b_reg = 3'd0;
  logic [5:0] r1 = 6'd0, r2 = 6'd0, y_reg = 6'd0;
  logic [5:0] inp1, alu_out;
  logic       eq_force0 = 1'b0;

  mult_controller dut (
    .SYS_CLOCK(SYS_CLOCK), .SYS_RESET(SYS_RESET), .START(START), .B(B), .EQUAL(EQUAL),
    .MUX_IN1_CONT(MUX_IN1_CONT), .MUX_IN2_CONT(MUX_IN2_CONT), .ALU_CONT(ALU_CONT),
    .LOAD_A_REG(LOAD_A_REG), .LOAD_B_REG(LOAD_B_REG), .LOAD_R1_REG(LOAD_R1_REG),
    .LOAD_R2_REG(LOAD_R2_REG), .LOAD_Y_REG(LOAD_Y_REG),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 SYS_CLOCK = ~SYS_CLOCK;

  // Datapath stand-in: mux/ALU decode straight from the datapath opcode table.
  always_comb begin
    inp1 = (MUX_IN1_CONT == 2'd1) ? {3'b000, a_reg} : r2;
    case (ALU_CONT)
      3'b000:  alu_out = inp1 + 6'd1;
      3'b001:  alu_out = inp1 + r1;
      default: alu_out = 6'd0;
    endcase
  end

  assign EQUAL = !eq_force0 && (r2[2:0] == (b_reg - 3'd1));

  always @(posedge SYS_CLOCK) begin
    if (LOAD_A_REG)  a_reg <= a_in;
    if (LOAD_B_REG)  b_reg <= B;
    if (LOAD_R1_REG) r1    <= alu_out;
    if (LOAD_R2_REG) r2    <= alu_out;
    if (LOAD_Y_REG)  y_reg <= r1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge SYS_CLOCK);
    #1;
  endtask

  // Starts a multiply in the current (IDLE) cycle = cycle 0; returns in the DONE cycle.
  task automatic run_mult(input logic [2:0] a, input logic [2:0] b,
                          output int done_cyc, output int adds, output int ly_cyc,
                          output logic busy_ok, output logic load_ok);
    a_in = a;
    B = b;
    START = 1'b1;
    #1;
    load_ok = (LOAD_A_REG === 1'b1) && (LOAD_B_REG === 1'b1);
    busy_ok = (BUSY === 1'b0);
    adds = 0;
    done_cyc = -1;
    ly_cyc = -1;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      tick();
      START = 1'b0;
      if (BUSY !== 1'b1) busy_ok = 1'b0;
      if (ALU_CONT === ALU_ADD && LOAD_R1_REG === 1'b1) adds++;
      if (LOAD_Y_REG === 1'b1) ly_cyc = c;
      if (DONE === 1'b1) done_cyc = c;
    end
  endtask

  task automatic test_reset();
    SYS_RESET = 1'b1;
    START = 1'b1;
    a_in = 3'd3;
    B = 3'd2;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({BUSY, DONE, ERROR} !== 3'b000)
        $display("FAIL reset_flags: got %b expected 000", {BUSY, DONE, ERROR});
      else passed++;
      checks++;
      if ({LOAD_A_REG, LOAD_B_REG, LOAD_R1_REG, LOAD_R2_REG, LOAD_Y_REG} !== 5'b00000)
        $display("FAIL reset_loads: got %b expected 00000",
                 {LOAD_A_REG, LOAD_B_REG, LOAD_R1_REG, LOAD_R2_REG, LOAD_Y_REG});
      else passed++;
      checks++;
      if ({MUX_IN1_CONT, MUX_IN2_CONT, ALU_CONT} !== 7'b0000010)
        $display("FAIL reset_selects: got %b expected 0000010",
                 {MUX_IN1_CONT, MUX_IN2_CONT, ALU_CONT});
      else passed++;
    end
    SYS_RESET = 1'b0;
    START = 1'b0;
    tick();
    tick();
    checks++;
    if (BUSY !== 1'b0 || LOAD_R1_REG !== 1'b0)
      $display("FAIL reset_start_ignored: busy=%b load_r1=%b expected 0 0", BUSY, LOAD_R1_REG);
    else passed++;
  endtask

  task automatic test_normal(input string name, input logic [2:0] a, input logic [2:0] b,
                             input int exp_done, input int exp_adds, input logic [5:0] exp_y);
    int d, n, ly;
    logic bok, lok;
    run_mult(a, b, d, n, ly, bok, lok);
    checks++;
    if (d !== exp_done) $display("FAIL %s_done_cycle: got %0d expected %0d", name, d, exp_done);
    else passed++;
    checks++;
    if (n !== exp_adds) $display("FAIL %s_adds: got %0d expected %0d", name, n, exp_adds);
    else passed++;
    checks++;
    if (y_reg !== exp_y) $display("FAIL %s_y: got %0d expected %0d", name, y_reg, exp_y);
    else passed++;
    checks++;
    if (ERROR !== 1'b0) $display("FAIL %s_error: got %b expected 0", name, ERROR);
    else passed++;
    checks++;
    if (!bok || !lok || ly !== exp_done - 1)
      $display("FAIL %s_handshake: busy_ok=%b load_ok=%b load_y_cycle=%0d expected 1 1 %0d",
               name, bok, lok, ly, exp_done - 1);
    else passed++;
    tick();
  endtask

  task automatic test_watchdog();
    int d, n, ly;
    logic bok, lok;
    eq_force0 = 1'b1;
    run_mult(3'd2, 3'd4, d, n, ly, bok, lok);
    checks++;
    if (d !== 16) $display("FAIL wd_done_cycle: got %0d expected 16", d);
    else passed++;
    checks++;
    if (n !== 7) $display("FAIL wd_adds: got %0d expected 7", n);
    else passed++;
    checks++;
    if (ERROR !== 1'b1 || y_reg !== 6'd14)
      $display("FAIL wd_error_y: error=%b y=%0d expected 1 14", ERROR, y_reg);
    else passed++;
    tick();
    checks++;
    if (ERROR !== 1'b1 || BUSY !== 1'b0)
      $display("FAIL wd_sticky_idle: error=%b busy=%b expected 1 0", ERROR, BUSY);
    else passed++;
    eq_force0 = 1'b0;
    run_mult(3'd5, 3'd1, d, n, ly, bok, lok);
    checks++;
    if (d !== 4 || y_reg !== 6'd5)
      $display("FAIL wd_next_run: done=%0d y=%0d expected 4 5", d, y_reg);
    else passed++;
    checks++;
    if (ERROR !== 1'b0) $display("FAIL wd_error_cleared: got %b expected 0", ERROR);
    else passed++;
  endtask

  // Re-START while busy and a reset mid-run, then a clean run right after.
  task automatic test_abort();
    tick();
    a_in = 3'd3;
    B = 3'd6;
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    B = 3'd1;
    START = 1'b1;
    #1;
    checks++;
    if (LOAD_A_REG !== 1'b0 || LOAD_B_REG !== 1'b0 || BUSY !== 1'b1)
      $display("FAIL busy_restart_loads: la=%b lb=%b busy=%b expected 0 0 1",
               LOAD_A_REG, LOAD_B_REG, BUSY);
    else passed++;
    tick();
    START = 1'b0;
    B = 3'd6;
    checks++;
    if (b_reg !== 3'd6) $display("FAIL busy_restart_breg: got %0d expected 6", b_reg);
    else passed++;
    SYS_RESET = 1'b1;
    tick();
    SYS_RESET = 1'b0;
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || LOAD_Y_REG !== 1'b0)
      $display("FAIL midrun_reset: busy=%b done=%b load_y=%b expected 0 0 0",
               BUSY, DONE, LOAD_Y_REG);
    else passed++;
    test_normal("after_reset", 3'd3, 3'd6, 14, 6, 6'd18);
  endtask

  initial begin
    SYS_RESET = 1'b1;
    START = 1'b0;
    B = 3'd0;
    test_reset();
    test_normal("a5_b3", 3'd5, 3'd3, 8, 3, 6'd15);
    test_normal("a7_b7", 3'd7, 3'd7, 16, 7, 6'd49);
    test_normal("a6_b0", 3'd6, 3'd0, 3, 0, 6'd0);
    test_normal("a0_b5", 3'd0, 3'd5, 12, 5, 6'd0);
    test_watchdog();
    test_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
